// File: rtl/vend_pkg.sv
// Shared types and default sizing for the drink vending controller.
package vend_pkg;

    localparam int unsigned DEF_N_DRINKS = 4;
    localparam int unsigned DEF_N_STEPS  = 5;
    localparam int unsigned DEF_CREDIT_W = 8;
    localparam int unsigned STATE_W      = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_DISPENSE = 3'd1,
        ST_CHANGE   = 3'd2,
        ST_DONE     = 3'd3
    } vend_state_e;

    // Index width that stays legal for single-entry tables.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vend_step_sel.sv
// Finds the lowest enabled dispense step above (or at, when i_incl) a given step index.
module vend_step_sel
    import vend_pkg::*;
#(
    parameter  int unsigned N_STEPS = DEF_N_STEPS,
    localparam int unsigned STEP_W  = idx_w(N_STEPS)
) (
    input  logic [N_STEPS-1:0] i_mask,
    input  logic [STEP_W-1:0]  i_idx,
    input  logic               i_incl,
    output logic [STEP_W-1:0]  o_idx_c,
    output logic               o_none_c
);

    // Scan downwards so the lowest qualifying step is the last one written.
    always_comb begin
        o_idx_c  = '0;
        o_none_c = 1'b1;
        for (int i = int'(N_STEPS) - 1; i >= 0; i--) begin
            if (i_mask[i] && ((i > int'(i_idx)) || (i_incl && (i == int'(i_idx))))) begin
                o_idx_c  = STEP_W'(i);
                o_none_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/drink_vend_ctrl.sv
// Drink vending controller: coin credit, selection, stepped dispense, change and done handshake.
module drink_vend_ctrl
    import vend_pkg::*;
#(
    parameter  int unsigned N_DRINKS = DEF_N_DRINKS,
    parameter  int unsigned N_STEPS  = DEF_N_STEPS,
    parameter  int unsigned CREDIT_W = DEF_CREDIT_W,
    localparam int unsigned SEL_W    = idx_w(N_DRINKS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coin_valid,
    input  logic [CREDIT_W-1:0]          coin_amt,
    input  logic                         sel_valid,
    input  logic [SEL_W-1:0]             sel_idx,
    input  logic                         cancel,
    input  logic                         tick,
    input  logic [N_DRINKS*CREDIT_W-1:0] price_tbl,
    input  logic [N_DRINKS*N_STEPS-1:0]  recipe_tbl,
    output logic [N_STEPS-1:0]           step_en,
    output logic                         rst_timer,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         coin_reject,
    output logic                         err_insuf,
    output logic                         change_valid,
    output logic [CREDIT_W-1:0]          change_amt,
    output logic                         done,
    output logic                         busy,
    output logic [STATE_W-1:0]           state_o
);

    localparam int unsigned STEP_W = idx_w(N_STEPS);

    vend_state_e         r_state;
    vend_state_e         w_state_nxt;

    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_price;
    logic [SEL_W-1:0]    r_drink;
    logic [STEP_W-1:0]   r_step;
    logic                r_vend;
    logic                r_busy;
    logic [N_STEPS-1:0]  r_step_en;
    logic                r_rst_timer;
    logic                r_coin_reject;
    logic                r_err_insuf;
    logic                r_change_valid;
    logic [CREDIT_W-1:0] r_change_amt;
    logic                r_done;

    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [CREDIT_W-1:0] w_price_nxt;
    logic [SEL_W-1:0]    w_drink_nxt;
    logic [STEP_W-1:0]   w_step_nxt;
    logic                w_vend_nxt;
    logic [N_STEPS-1:0]  w_step_en_nxt;
    logic                w_rst_timer_nxt;
    logic                w_coin_reject_nxt;
    logic                w_err_insuf_nxt;
    logic                w_change_valid_nxt;
    logic [CREDIT_W-1:0] w_change_amt_nxt;
    logic                w_done_nxt;

    logic [CREDIT_W-1:0] w_sel_price;
    logic [N_STEPS-1:0]  w_sel_mask;
    logic [N_STEPS-1:0]  w_cur_mask;
    logic                w_sel_in_range;
    logic [CREDIT_W:0]   w_sum;
    logic                w_coin_fits;
    logic                w_afford;
    logic                w_cancel_go;
    logic                w_sel_req;
    logic                w_sel_go;
    logic [STEP_W-1:0]   w_first_idx;
    logic                w_first_none;
    logic [STEP_W-1:0]   w_next_idx;
    logic                w_next_none;

    // Table lookups for the incoming selection and the drink being dispensed.
    always_comb begin
        w_sel_price = '0;
        w_sel_mask  = '0;
        w_cur_mask  = '0;
        for (int d = 0; d < int'(N_DRINKS); d++) begin
            if (d == int'(sel_idx)) begin
                w_sel_price = price_tbl[d*CREDIT_W +: CREDIT_W];
                w_sel_mask  = recipe_tbl[d*N_STEPS +: N_STEPS];
            end
            if (d == int'(r_drink)) begin
                w_cur_mask = recipe_tbl[d*N_STEPS +: N_STEPS];
            end
        end
    end

    assign w_sel_in_range = int'(sel_idx) < int'(N_DRINKS);
    assign w_sum          = {1'b0, r_credit} + {1'b0, coin_amt};
    assign w_coin_fits    = ~w_sum[CREDIT_W];
    assign w_afford       = r_credit >= w_sel_price;
    assign w_cancel_go    = cancel && (r_credit != '0);
    assign w_sel_req      = sel_valid && w_sel_in_range;
    assign w_sel_go       = w_sel_req && w_afford;

    vend_step_sel #(.N_STEPS(N_STEPS)) u_first_step (
        .i_mask   (w_sel_mask),
        .i_idx    ('0),
        .i_incl   (1'b1),
        .o_idx_c  (w_first_idx),
        .o_none_c (w_first_none)
    );

    vend_step_sel #(.N_STEPS(N_STEPS)) u_next_step (
        .i_mask   (w_cur_mask),
        .i_idx    (r_step),
        .i_incl   (1'b0),
        .o_idx_c  (w_next_idx),
        .o_none_c (w_next_none)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A cancel pulse owns the IDLE cycle even when there is no credit to return.
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (cancel) begin
                    w_state_nxt = w_cancel_go ? ST_CHANGE : ST_IDLE;
                end else if (w_sel_go) begin
                    w_state_nxt = w_first_none ? ST_CHANGE : ST_DISPENSE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DISPENSE: w_state_nxt = (tick && w_next_none) ? ST_CHANGE : ST_DISPENSE;
            ST_CHANGE:   w_state_nxt = ST_DONE;
            ST_DONE:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_credit_nxt       = r_credit;
        w_price_nxt        = r_price;
        w_drink_nxt        = r_drink;
        w_step_nxt         = r_step;
        w_vend_nxt         = r_vend;
        w_change_amt_nxt   = r_change_amt;
        w_coin_reject_nxt  = 1'b0;
        w_err_insuf_nxt    = 1'b0;
        w_rst_timer_nxt    = 1'b0;
        w_change_valid_nxt = 1'b0;
        w_done_nxt         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cancel) begin
                    w_coin_reject_nxt = coin_valid;
                    if (w_cancel_go) begin
                        w_change_valid_nxt = 1'b1;
                        w_change_amt_nxt   = r_credit;
                        w_vend_nxt         = 1'b0;
                    end
                end else if (w_sel_req) begin
                    w_coin_reject_nxt = coin_valid;
                    if (w_afford) begin
                        w_drink_nxt = sel_idx;
                        w_price_nxt = w_sel_price;
                        w_vend_nxt  = 1'b1;
                        if (w_first_none) begin
                            w_change_valid_nxt = 1'b1;
                            w_change_amt_nxt   = r_credit - w_sel_price;
                        end else begin
                            w_step_nxt      = w_first_idx;
                            w_rst_timer_nxt = 1'b1;
                        end
                    end else begin
                        w_err_insuf_nxt = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (w_coin_fits) begin
                        w_credit_nxt = w_sum[CREDIT_W-1:0];
                    end else begin
                        w_coin_reject_nxt = 1'b1;
                    end
                end
            end
            ST_DISPENSE: begin
                w_coin_reject_nxt = coin_valid;
                if (tick) begin
                    w_rst_timer_nxt = 1'b1;
                    if (w_next_none) begin
                        w_change_valid_nxt = 1'b1;
                        w_change_amt_nxt   = r_credit - r_price;
                    end else begin
                        w_step_nxt = w_next_idx;
                    end
                end
            end
            ST_CHANGE: begin
                w_coin_reject_nxt = coin_valid;
                w_credit_nxt      = '0;
                w_done_nxt        = r_vend;
            end
            ST_DONE: begin
                w_coin_reject_nxt = coin_valid;
            end
            default: begin
                w_coin_reject_nxt = coin_valid;
            end
        endcase
        w_step_en_nxt = (w_state_nxt == ST_DISPENSE) ? (N_STEPS'(1) << w_step_nxt) : '0;
    end

    // Datapath and registered outputs; reset discards any in-flight vend and its credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit       <= '0;
            r_price        <= '0;
            r_drink        <= '0;
            r_step         <= '0;
            r_vend         <= 1'b0;
            r_busy         <= 1'b0;
            r_step_en      <= '0;
            r_rst_timer    <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_err_insuf    <= 1'b0;
            r_change_valid <= 1'b0;
            r_change_amt   <= '0;
            r_done         <= 1'b0;
        end else begin
            r_credit       <= w_credit_nxt;
            r_price        <= w_price_nxt;
            r_drink        <= w_drink_nxt;
            r_step         <= w_step_nxt;
            r_vend         <= w_vend_nxt;
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_step_en      <= w_step_en_nxt;
            r_rst_timer    <= w_rst_timer_nxt;
            r_coin_reject  <= w_coin_reject_nxt;
            r_err_insuf    <= w_err_insuf_nxt;
            r_change_valid <= w_change_valid_nxt;
            r_change_amt   <= w_change_amt_nxt;
            r_done         <= w_done_nxt;
        end
    end

    assign step_en      = r_step_en;
    assign rst_timer    = r_rst_timer;
    assign credit       = r_credit;
    assign coin_reject  = r_coin_reject;
    assign err_insuf    = r_err_insuf;
    assign change_valid = r_change_valid;
    assign change_amt   = r_change_amt;
    assign done         = r_done;
    assign busy         = r_busy;
    assign state_o      = r_state;

endmodule
